aes_inv_key_schedule: RTL and testbench
=======================================

# aes_inv_key_schedule

Sequential AES-128 key schedule unit for the decryption datapath. It produces the eleven round keys in reverse order, round 10 down to round 0, at one key per accepted handshake, so the inverse cipher never stores the full 1408-bit schedule. From a cipher key it first runs the forward expansion iteratively to reach the round-10 key. It can also be loaded directly with a round-10 key and unwind from there.

## Interface
- No parameters. AES-128 only, Nk=4, Nr=10.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted on an edge where start && in_ready.
- key_in  in  [0:127]  cipher key, or round-10 key if key_is_final=1; bit 0 = MSB of byte 0; sampled at acceptance.
- key_is_final  in  1  selects the key_in meaning; sampled at acceptance.
- in_ready  out  1  high only in IDLE.
- busy  out  1  high in EXPAND and EMIT.
- round_key  out  [0:127]  current round key, same bit ordering as key_in.
- round_idx  out  4  round number of round_key, 10 down to 0.
- key_valid  out  1  round_key/round_idx valid.
- key_ready  in  1  consumer accepts; handshake = key_valid && key_ready.
- key_last  out  1  high with key_valid when round_idx==0.

## Operation
- States: IDLE, EXPAND, EMIT. A 128-bit key register kr and a 4-bit round counter rc.
- IDLE → EXPAND on acceptance with key_is_final=0: kr ← key_in, rc ← 0.
- IDLE → EMIT on acceptance with key_is_final=1: kr ← key_in, rc ← 10.
- EXPAND forward step, each cycle, with words w0..w3 = kr[0:31]..kr[96:127] and r = rc+1:
  - t = SubWord(RotWord(w3)) ^ {Rcon[r], 24'h0}
  - n0=w0^t; n1=w1^n0; n2=w2^n1; n3=w3^n2
  - kr ← {n0,n1,n2,n3}, rc ← r
  - Move to EMIT when rc becomes 10.
- EMIT: round_key=kr, round_idx=rc, key_valid=1.
- On a handshake with rc>0, apply the inverse step:
  - p3=w3^w2; p2=w2^w1; p1=w1^w0
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {Rcon[rc], 24'h0}
  - kr ← {p0,p1,p2,p3}, rc ← rc−1
- On a handshake with rc==0, go to IDLE.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36. Standard AES S-box. All XORs are 32-bit with no carries.
- start is ignored when in_ready=0. key_ready is ignored when key_valid=0.
- Rcon index is always within 1..10; other values are unreachable.

## Timing
- Reset values: in_ready=1, busy=0, key_valid=0, key_last=0, round_idx=0, round_key=0. Internal state is IDLE, kr=0, rc=0.
- Reset asserted mid-operation forces reset values immediately and abandons the sequence. There is no partial output after reset is released.
- Latency, key_is_final=0: acceptance at edge E0; key_valid rises after E10, giving round 10 ten cycles after acceptance.
- Latency, key_is_final=1: key_valid rises after E0, one cycle after acceptance.
- Throughput: one round key per cycle under continuous key_ready; eleven keys in eleven consecutive handshakes.
- Backpressure: while key_valid && !key_ready, round_key, round_idx and key_last hold stable.
- Completion: in_ready rises the cycle after the round-0 handshake. The earliest new acceptance is on the edge after that.
- Outputs are registered or decoded from state only. There is no combinational path from key_ready or start to any output.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, key_is_final=0, key_ready=1:
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, 10 cycles after acceptance
  - round 1 = a0fafe1788542cb123a339392a6c7605
  - round 0 = key_in with key_last=1
  - in_ready high the next cycle
- All-zero key: round 10 = b4ef5bcb3e92e21123e951cf6f8f188e, round 1 = 62636363626363636263636362636363, round 0 = 0.
- key_is_final=1 with key_in = d014f9a8c9ee2589e13f0cc8b6630ca6: key_valid the cycle after acceptance; the sequence matches the FIPS case down to 2b7e1516…4f3c.
- Random key_ready toggling at roughly 50%: outputs stable during stalls; exactly 11 handshakes with round_idx strictly 10→0; no duplicated or skipped keys.
- start pulsed with a different key during EXPAND and EMIT: ignored, and the original sequence is unchanged.
- rst asserted at round_idx=5: key_valid=0 and in_ready=1 immediately. A new start after release produces a correct full sequence.

Source files
------------

// File: rtl/aes_inv_key_schedule_if.sv
// aes_inv_key_schedule_if: request and round-key stream signals of the inverse AES-128 key schedule.
// Key vectors use ascending ranges so that bit 0 is the MSB of byte 0.
interface aes_inv_key_schedule_if;
    logic           start;
    logic [0:127]   key_in;
    logic           key_is_final;
    logic           in_ready;
    logic           busy;
    logic [0:127]   round_key;
    logic [3:0]     round_idx;
    logic           key_valid;
    logic           key_ready;
    logic           key_last;
    modport slave (
        input  start, key_in, key_is_final, key_ready,
        output in_ready, busy, round_key, round_idx, key_valid, key_last
    );
    modport master (
        output start, key_in, key_is_final, key_ready,
        input  in_ready, busy, round_key, round_idx, key_valid, key_last
    );
endinterface

// File: rtl/aes_inv_key_schedule.sv
// aes_inv_key_schedule: emits AES-128 round keys 10 down to 0, one per handshake.
// A cipher key is first expanded forward to round 10; a round-10 key is unwound directly.
module aes_inv_key_schedule (
    input logic                   clk,
    input logic                   rst,
    aes_inv_key_schedule_if.slave ks
);
    typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_e;
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };
    state_e       state_q, state_d;
    logic [127:0] kr_q, kr_d, fwd, inv;
    logic [3:0]   rc_q, rc_d, rcon_idx;
    logic [31:0]  w0, w1, w2, w3, sw_in, t, n0, n1, n2;
    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction
    // One SubWord serves both directions: w3 going forward, the recovered old w3 (w3^w2) going back.
    always_comb begin
        {w0, w1, w2, w3} = kr_q;
        sw_in    = (state_q == EXPAND) ? w3 : w3 ^ w2;
        rcon_idx = (state_q == EXPAND) ? rc_q + 4'd1 : rc_q;
        t        = sub_word({sw_in[23:0], sw_in[31:24]}) ^ {RCON[rcon_idx], 24'h0};
        n0       = w0 ^ t;
        n1       = w1 ^ n0;
        n2       = w2 ^ n1;
        fwd      = {n0, n1, n2, w3 ^ n2};
        inv      = {w0 ^ t, w1 ^ w0, w2 ^ w1, w3 ^ w2};
    end
    always_comb begin
        state_d = state_q;
        kr_d    = kr_q;
        rc_d    = rc_q;
        case (state_q)
            IDLE: if (ks.start) begin
                state_d = ks.key_is_final ? EMIT : EXPAND;
                kr_d    = ks.key_in;
                rc_d    = ks.key_is_final ? 4'd10 : 4'd0;
            end
            EXPAND: begin
                kr_d    = fwd;
                rc_d    = rc_q + 4'd1;
                state_d = (rc_q == 4'd9) ? EMIT : EXPAND;
            end
            EMIT: if (ks.key_ready) begin
                state_d = (rc_q == 4'd0) ? IDLE : EMIT;
                kr_d    = (rc_q == 4'd0) ? kr_q : inv;
                rc_d    = (rc_q == 4'd0) ? rc_q : rc_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            kr_q    <= '0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            kr_q    <= kr_d;
            rc_q    <= rc_d;
        end
    end
    assign ks.in_ready  = (state_q == IDLE);
    assign ks.busy      = (state_q != IDLE);
    assign ks.key_valid = (state_q == EMIT);
    assign ks.key_last  = (state_q == EMIT) && (rc_q == 4'd0);
    assign ks.round_key = kr_q;
    assign ks.round_idx = rc_q;
endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// tb_aes_inv_key_schedule: directed FIPS-197 and all-zero key vectors for the inverse key schedule.
module tb_aes_inv_key_schedule;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails = 0;
    aes_inv_key_schedule_if ks ();
    aes_inv_key_schedule dut (.clk(clk), .rst(rst), .ks(ks));
    always #5 clk = ~clk;
    localparam logic [127:0] FIPS [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam logic [127:0] ZERO10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] ZERO1  = 128'h62636363626363636263636362636363;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic do_start(input logic [127:0] k, input logic fin);
        ks.start = 1'b1;
        ks.key_in = k;
        ks.key_is_final = fin;
        step();
        ks.start = 1'b0;
        ks.key_in = '0;
        ks.key_is_final = 1'b0;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (ks.in_ready !== 1'b1 || ks.busy !== 1'b0 || ks.key_valid !== 1'b0 || ks.key_last !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: in_ready=%b busy=%b valid=%b last=%b want 1 0 0 0", ks.in_ready, ks.busy, ks.key_valid, ks.key_last);
        end
        checks++;
        if (ks.round_idx !== 4'd0 || ks.round_key !== 128'h0) begin
            fails++;
            $display("FAIL reset_data: idx=%0d key=%h want 0 0", ks.round_idx, ks.round_key);
        end
        rst = 1'b0;
        step();
    endtask
    task automatic test_fips();
        int n = 0;
        ks.key_ready = 1'b1;
        do_start(FIPS[0], 1'b0);
        checks++;
        if (ks.busy !== 1'b1 || ks.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL fips_busy: busy=%b in_ready=%b want 1 0", ks.busy, ks.in_ready);
        end
        while (ks.key_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (n != 10) begin
            fails++;
            $display("FAIL fips_latency: got %0d cycles want 10", n);
        end
        for (int r = 10; r >= 0; r--) begin
            checks++;
            if (ks.key_valid !== 1'b1 || ks.round_idx !== 4'(r) || ks.round_key !== FIPS[r] || ks.key_last !== (r == 0)) begin
                fails++;
                $display("FAIL fips_r%0d: valid=%b idx=%0d key=%h last=%b want 1 %0d %h %b", r, ks.key_valid, ks.round_idx, ks.round_key, ks.key_last, r, FIPS[r], r == 0);
            end
            step();
        end
        checks++;
        if (ks.in_ready !== 1'b1 || ks.key_valid !== 1'b0) begin
            fails++;
            $display("FAIL fips_done: in_ready=%b valid=%b want 1 0", ks.in_ready, ks.key_valid);
        end
    endtask
    task automatic test_zero();
        int n = 0;
        logic [127:0] want;
        ks.key_ready = 1'b1;
        do_start(128'h0, 1'b0);
        while (ks.key_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        for (int r = 10; r >= 0; r--) begin
            want = (r == 10) ? ZERO10 : (r == 1) ? ZERO1 : 128'h0;
            checks++;
            if (ks.round_idx !== 4'(r) || ((r == 10 || r <= 1) && ks.round_key !== want)) begin
                fails++;
                $display("FAIL zero_r%0d: idx=%0d key=%h want %0d %h", r, ks.round_idx, ks.round_key, r, want);
            end
            step();
        end
    endtask
    task automatic test_final_load();
        ks.key_ready = 1'b1;
        do_start(FIPS[10], 1'b1);
        checks++;
        if (ks.key_valid !== 1'b1) begin
            fails++;
            $display("FAIL final_latency: valid=%b want 1 one cycle after accept", ks.key_valid);
        end
        for (int r = 10; r >= 0; r--) begin
            checks++;
            if (ks.round_idx !== 4'(r) || ks.round_key !== FIPS[r] || ks.key_last !== (r == 0)) begin
                fails++;
                $display("FAIL final_r%0d: idx=%0d key=%h last=%b want %0d %h %b", r, ks.round_idx, ks.round_key, ks.key_last, r, FIPS[r], r == 0);
            end
            step();
        end
        checks++;
        if (ks.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL final_done: in_ready=%b want 1", ks.in_ready);
        end
    endtask
    task automatic test_backpressure();
        int exp_r = 10;
        int hs = 0;
        int cyc = 0;
        int stalls = 0;
        ks.key_ready = 1'b0;
        do_start(FIPS[10], 1'b1);
        while (hs < 11 && cyc < 300) begin
            checks++;
            if (ks.key_valid !== 1'b1 || ks.round_idx !== 4'(exp_r) || ks.round_key !== FIPS[exp_r] || ks.key_last !== (exp_r == 0)) begin
                fails++;
                $display("FAIL bp_r%0d: valid=%b idx=%0d key=%h last=%b want 1 %0d %h %b", exp_r, ks.key_valid, ks.round_idx, ks.round_key, ks.key_last, exp_r, FIPS[exp_r], exp_r == 0);
            end
            ks.key_ready = 1'($urandom_range(0, 1));
            if (ks.key_ready) begin
                hs++;
                exp_r--;
            end else begin
                stalls++;
            end
            step();
            cyc++;
        end
        ks.key_ready = 1'b0;
        checks++;
        if (hs != 11 || ks.in_ready !== 1'b1 || ks.key_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_done: handshakes=%0d in_ready=%b valid=%b want 11 1 0 (stalls=%0d)", hs, ks.in_ready, ks.key_valid, stalls);
        end
    endtask
    task automatic test_start_ignored();
        int n = 4;
        ks.key_ready = 1'b1;
        do_start(FIPS[0], 1'b0);
        step();
        step();
        step();
        ks.start = 1'b1;
        ks.key_in = '1;
        ks.key_is_final = 1'b1;
        step();
        ks.start = 1'b0;
        while (ks.key_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (n != 10) begin
            fails++;
            $display("FAIL ign_latency: got %0d cycles want 10", n);
        end
        for (int r = 10; r >= 0; r--) begin
            checks++;
            if (ks.round_idx !== 4'(r) || ks.round_key !== FIPS[r]) begin
                fails++;
                $display("FAIL ign_r%0d: idx=%0d key=%h want %0d %h", r, ks.round_idx, ks.round_key, r, FIPS[r]);
            end
            ks.start = (r == 5);
            step();
        end
        ks.start = 1'b0;
        ks.key_is_final = 1'b0;
        ks.key_in = '0;
        checks++;
        if (ks.in_ready !== 1'b1 || ks.busy !== 1'b0) begin
            fails++;
            $display("FAIL ign_done: in_ready=%b busy=%b want 1 0", ks.in_ready, ks.busy);
        end
    endtask
    task automatic test_reset_mid();
        int n = 0;
        ks.key_ready = 1'b1;
        do_start(FIPS[10], 1'b1);
        repeat (5) step();
        checks++;
        if (ks.round_idx !== 4'd5) begin
            fails++;
            $display("FAIL rst_pre: idx=%0d want 5", ks.round_idx);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ks.key_valid !== 1'b0 || ks.in_ready !== 1'b1 || ks.busy !== 1'b0 || ks.round_idx !== 4'd0 || ks.round_key !== 128'h0) begin
            fails++;
            $display("FAIL rst_async: valid=%b in_ready=%b busy=%b idx=%0d key=%h want 0 1 0 0 0", ks.key_valid, ks.in_ready, ks.busy, ks.round_idx, ks.round_key);
        end
        step();
        step();
        rst = 1'b0;
        step();
        checks++;
        if (ks.key_valid !== 1'b0 || ks.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_release: valid=%b in_ready=%b want 0 1", ks.key_valid, ks.in_ready);
        end
        do_start(FIPS[0], 1'b0);
        while (ks.key_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        for (int r = 10; r >= 0; r--) begin
            checks++;
            if (ks.round_idx !== 4'(r) || ks.round_key !== FIPS[r] || ks.key_last !== (r == 0)) begin
                fails++;
                $display("FAIL rst_seq_r%0d: idx=%0d key=%h last=%b want %0d %h %b", r, ks.round_idx, ks.round_key, ks.key_last, r, FIPS[r], r == 0);
            end
            step();
        end
    endtask
    initial begin
        ks.start = 1'b0;
        ks.key_in = '0;
        ks.key_is_final = 1'b0;
        ks.key_ready = 1'b0;
        test_reset();
        test_fips();
        test_zero();
        test_final_load();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
